branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Pipelined branch/compare resolution unit for the execute stage. Successor to the combinational branch comparator.
- Generalised to XLEN and to 1 or 2 pipeline stages, with a valid/ready handshake.
- Adds branch target/fall-through computation, misprediction detection, a redirect PC, pipeline flush and a saturating mispredict counter.

Parameters:
- XLEN, 32, operand and PC width (32 or 64).
- STAGES, 1, register stages from accept to result (1 or 2 only; any other value is a synthesis-time error).
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  unit can accept this cycle
- in_rs1  in  XLEN  operand 1
- in_rs2  in  XLEN  operand 2
- in_cond  in  3  funct3 condition code
- in_branch  in  1  1 = conditional branch, 0 = SLT/SLTU compare
- in_pred_taken  in  1  front-end prediction
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended branch offset
- flush  in  1  kill all in-flight operations
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  1  raw condition result
- out_taken  out  1  actual branch outcome
- out_mispredict  out  1  redirect required
- out_redirect_pc  out  XLEN  correct next PC
- ctr_clr  in  1  synchronous clear of the counter
- mispredict_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all valid bits 0, out_valid 0, all data outputs 0, mispredict_cnt 0.
- Condition codes (in_cond):
  - 000 EQ, 001 NE
  - 100 LT signed, 101 GE signed
  - 110 LTU, 111 GEU
  - 010 SLT, which evaluates as LT signed
  - 011 SLTU, which evaluates as LTU
- Outputs per accepted operation:
  - out_result = evaluated condition.
  - out_taken = in_branch & out_result.
  - target = in_pc + in_imm, fall = in_pc + 4, both mod 2^XLEN (wrap-around, no overflow flag).
  - out_mispredict = in_branch ? (out_taken != in_pred_taken) : in_pred_taken.
  - out_redirect_pc = out_taken ? target : fall. Meaningful only when out_mispredict = 1, but always driven.
- Handshake:
  - Accept when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_* hold stable while out_valid & !out_ready.
  - Inputs are don't-care when in_valid = 0.
- STAGES = 1:
  - One result register.
  - in_ready = !out_valid | out_ready.
  - Latency 1 cycle; full throughput with out_ready held high.
- STAGES = 2:
  - Stage 1 registers the EQ/LT/LTU flags, target, fall, cond, branch and pred.
  - Stage 2 registers the final outputs.
  - Each stage advances when its successor is empty or draining.
  - in_ready = !s1_valid | s1_advance.
  - Latency 2 cycles, one op per cycle sustained.
  - Bubbles collapse: an empty stage 2 always loads a valid stage 1.
- Flush:
  - At the next edge all valid bits clear.
  - An input offered in the flush cycle is dropped. in_ready may be high, but nothing is captured.
  - An output transfer in the flush cycle still completes and is counted.
- Counter:
  - Increments on output transfer with out_mispredict = 1.
  - Saturates at 2^CNT_W - 1.
  - ctr_clr has priority over an increment in the same cycle; the result is 0.
- Reset mid-operation drops all in-flight ops immediately, asynchronously.

Decomposition:
- Shared package rv_branch_pkg holds:
  - the funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU, SLT, SLTU);
  - the PC increment constant 4.
- One natural sub-module: branch_cond_eval, the combinational XLEN-parametrised flag generator (EQ/LT/LTU) plus the cond mux. It is instantiated once, ahead of stage 1.

Test Plan:
- Compare semantics, STAGES=1, out_ready=1: rs1=0xFFFFFFFF, rs2=1.
  - LT gives result 1; LTU gives 0; GEU gives 1.
  - Each appears exactly one cycle after accept.
- Mispredict and redirect: BEQ, rs1=rs2=5, pc=0x100, imm=0x40, pred=0.
  - Expect taken=1, mispredict=1, redirect=0x140, cnt increments 0→1.
  - Repeat with pred=1: mispredict=0, cnt unchanged.
- Wrap and not-taken redirect: BNE, rs1=rs2, pc=0xFFFFFFFC, pred=1.
  - Expect taken=0, mispredict=1, redirect=0x00000000.
- Backpressure, STAGES=2: 4 back-to-back ops, out_ready low for cycles 3–5.
  - No op lost or duplicated; outputs stable while stalled.
  - in_ready drops only once both stages are full; in-order delivery.
- Flush, STAGES=2: 2 ops in flight, flush asserted with a new op offered.
  - Next cycle out_valid=0, and neither in-flight op nor the offered op ever emerges.
- Counter: CNT_W=2, 5 mispredicting transfers.
  - cnt sequence 1, 2, 3, 3, 3.
  - ctr_clr together with a mispredict transfer gives 0.
  - Assert rst mid-stream: out_valid falls without waiting for a clock edge.

Source files
------------

// File: rtl/rv_branch_pkg.sv
// Shared definitions for the branch resolution slice.
//   - funct3 condition codes for conditional branches and SLT/SLTU compares
//   - PC increment used for the fall-through address
package rv_branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] SLT  = 3'b010;
    localparam logic [2:0] SLTU = 3'b011;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator.
//   Flag generator : rs1/rs2 -> flag_eq, flag_lt (signed), flag_ltu (unsigned)
//   Cond mux       : cond + sel_eq/sel_lt/sel_ltu -> result
// The mux takes its flags on separate inputs so the parent can feed it either
// the live flags (single-stage) or flags registered one stage earlier.
// Ports:
//   rs1, rs2   in  XLEN  operands
//   flag_*     out 1     comparison flags of rs1 vs rs2
//   cond       in  3     funct3 condition code
//   sel_*      in  1     flags the mux evaluates cond against
//   result     out 1     evaluated condition
module branch_cond_eval
    import rv_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            flag_eq,
    output logic            flag_lt,
    output logic            flag_ltu,
    input  logic [2:0]      cond,
    input  logic            sel_eq,
    input  logic            sel_lt,
    input  logic            sel_ltu,
    output logic            result
);

    assign flag_eq  = (rs1 == rs2);
    assign flag_lt  = ($signed(rs1) < $signed(rs2));
    assign flag_ltu = (rs1 < rs2);

    always_comb begin
        result = 1'b0;
        case (cond)
            BEQ:        result = sel_eq;
            BNE:        result = !sel_eq;
            BLT, SLT:   result = sel_lt;
            BGE:        result = !sel_lt;
            BLTU, SLTU: result = sel_ltu;
            BGEU:       result = !sel_ltu;
            default:    result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch/compare resolution for the execute stage.
// Evaluates the condition, computes taken target and fall-through, detects a
// front-end misprediction and supplies the redirect PC. One or two register
// stages with a valid/ready handshake, a flush, and a saturating counter of
// mispredicting output transfers.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             upstream handshake
//   in_rs1, in_rs2, in_cond       operands and funct3 condition
//   in_branch, in_pred_taken      branch vs compare, predicted outcome
//   in_pc, in_imm                 instruction PC, sign-extended offset
//   flush                         drop everything in flight
//   out_valid/out_ready           downstream handshake
//   out_result, out_taken         raw condition, actual branch outcome
//   out_mispredict, out_redirect_pc  redirect request and correct next PC
//   ctr_clr, mispredict_cnt       counter clear and saturating count
module branch_resolve_unit
    import rv_branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [2:0]       in_cond,
    input  logic             in_branch,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect_pc,
    input  logic             ctr_clr,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] fall_c;
    logic            eq_c, lt_c, ltu_c;
    logic            accept;
    logic            out_free;

    // Operands feeding the final output register, from either the live
    // inputs (one stage) or the stage-1 register (two stages).
    logic            src_valid;
    logic [2:0]      sel_cond;
    logic            sel_eq, sel_lt, sel_ltu;
    logic            src_result;
    logic            src_branch;
    logic            src_pred;
    logic [XLEN-1:0] src_target;
    logic [XLEN-1:0] src_fall;

    logic            taken_c;
    logic            mispredict_c;
    logic [XLEN-1:0] redirect_c;

    assign target_c = in_pc + in_imm;
    assign fall_c   = in_pc + XLEN'(PC_INC);
    assign out_free = !out_valid || out_ready;
    // An op offered during a flush is never captured, even if in_ready is high.
    assign accept   = in_valid && in_ready && !flush;

    branch_cond_eval #(.XLEN(XLEN)) u_cond_eval (
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .flag_eq  (eq_c),
        .flag_lt  (lt_c),
        .flag_ltu (ltu_c),
        .cond     (sel_cond),
        .sel_eq   (sel_eq),
        .sel_lt   (sel_lt),
        .sel_ltu  (sel_ltu),
        .result   (src_result)
    );

    generate
        if (STAGES == 1) begin : g_one_stage
            assign in_ready   = out_free;
            assign src_valid  = accept;
            assign sel_cond   = in_cond;
            assign sel_eq     = eq_c;
            assign sel_lt     = lt_c;
            assign sel_ltu    = ltu_c;
            assign src_branch = in_branch;
            assign src_pred   = in_pred_taken;
            assign src_target = target_c;
            assign src_fall   = fall_c;
        end else if (STAGES == 2) begin : g_two_stage
            logic            s1_valid;
            logic            s1_eq, s1_lt, s1_ltu;
            logic [2:0]      s1_cond;
            logic            s1_branch;
            logic            s1_pred;
            logic [XLEN-1:0] s1_target;
            logic [XLEN-1:0] s1_fall;

            // Stage 1 moves whenever stage 2 is empty or draining, so an
            // empty stage 2 always absorbs a valid stage 1 (no bubbles).
            assign in_ready = !s1_valid || out_free;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid  <= 1'b0;
                    s1_eq     <= 1'b0;
                    s1_lt     <= 1'b0;
                    s1_ltu    <= 1'b0;
                    s1_cond   <= '0;
                    s1_branch <= 1'b0;
                    s1_pred   <= 1'b0;
                    s1_target <= '0;
                    s1_fall   <= '0;
                end else begin
                    if (flush) begin
                        s1_valid <= 1'b0;
                    end else if (in_ready) begin
                        s1_valid <= accept;
                    end
                    if (accept) begin
                        s1_eq     <= eq_c;
                        s1_lt     <= lt_c;
                        s1_ltu    <= ltu_c;
                        s1_cond   <= in_cond;
                        s1_branch <= in_branch;
                        s1_pred   <= in_pred_taken;
                        s1_target <= target_c;
                        s1_fall   <= fall_c;
                    end
                end
            end

            assign src_valid  = s1_valid;
            assign sel_cond   = s1_cond;
            assign sel_eq     = s1_eq;
            assign sel_lt     = s1_lt;
            assign sel_ltu    = s1_ltu;
            assign src_branch = s1_branch;
            assign src_pred   = s1_pred;
            assign src_target = s1_target;
            assign src_fall   = s1_fall;
        end else begin : g_bad_stages
            $error("branch_resolve_unit: STAGES must be 1 or 2");
        end
    endgenerate

    assign taken_c      = src_branch && src_result;
    // A compare is never a control transfer, so a taken prediction on it is wrong.
    assign mispredict_c = src_branch ? (taken_c != src_pred) : src_pred;
    assign redirect_c   = taken_c ? src_target : src_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_result      <= 1'b0;
            out_taken       <= 1'b0;
            out_mispredict  <= 1'b0;
            out_redirect_pc <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (out_free) begin
                out_valid <= src_valid;
            end
            if (!flush && out_free && src_valid) begin
                out_result      <= src_result;
                out_taken       <= taken_c;
                out_mispredict  <= mispredict_c;
                out_redirect_pc <= redirect_c;
            end
        end
    end

    // A transfer in a flush cycle still completes, so it is still counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (ctr_clr) begin
            mispredict_cnt <= '0;
        end else if (out_valid && out_ready && out_mispredict
                     && (mispredict_cnt != CNT_MAX)) begin
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

endmodule
